pu_accum_sched: RTL

//  Shares one pu_accum instance among N requesters. Each job is an operand stream (valid/ready, neg, last).

---
 rtl/pu_accum_sched_pkg.sv | 18 +
 rtl/pu_accum_sched_if.sv | 33 +++
 rtl/pu_accum_sched_rr_arbiter.sv | 34 +++
 rtl/pu_accum_sched.sv | 138 +++++++++++++
 4 files changed

// File: rtl/pu_accum_sched_pkg.sv
// Shared types for the accumulator scheduler: FSM state encoding.
// No logic, no latency.
// No flow control.
package pu_accum_sched_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_GAP   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OE    = 3'd4,
        ST_CAP   = 3'd5,
        ST_HOLD  = 3'd6
    } state_t;

endpackage

// File: rtl/pu_accum_sched_if.sv
// Requester operand streams plus the shared result channel.
// Pure wiring, no latency.
// req_valid/req_ready per requester, res_valid/res_ready for results.
interface pu_accum_sched_if
    import pu_accum_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ATTR_WIDTH = 4,
    parameter int N_REQ      = 4,
    parameter int ID_WIDTH   = 2
);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ*ATTR_WIDTH-1:0] req_attr;
    logic [N_REQ-1:0]            req_neg;
    logic [N_REQ-1:0]            req_last;
    logic                        res_valid;
    logic                        res_ready;
    logic [DATA_WIDTH-1:0]       res_data;
    logic [ATTR_WIDTH-1:0]       res_attr;
    logic [ID_WIDTH-1:0]         res_id;

    modport master (
        output req_valid, req_data, req_attr, req_neg, req_last, res_ready,
        input  req_ready, res_valid, res_data, res_attr, res_id
    );

    modport slave (
        input  req_valid, req_data, req_attr, req_neg, req_last, res_ready,
        output req_ready, res_valid, res_data, res_attr, res_id
    );
endinterface

// File: rtl/pu_accum_sched_rr_arbiter.sv
// Round-robin pick of the first requester at or after ptr.
// Combinational, zero latency.
// No flow control; grant is zero when nothing requests.
module rr_arbiter
    import pu_accum_sched_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_grant
);
    int cand;

    // Scan farthest-first so the closest candidate to ptr is the last write.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = 0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = (int'(ptr) + k) % N;
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
                any_grant   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/pu_accum_sched.sv
// Job-granular round-robin sharing of one pu_accum among N_REQ operand streams.
// Last operand accepted in cycle L -> res_valid in cycle L+4; 1 operand per 2 cycles.
// res_valid held until res_ready; other requesters see req_ready=0 until then.
module pu_accum_sched
    import pu_accum_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ATTR_WIDTH = 4,
    parameter int N_REQ      = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    pu_accum_sched_if.slave       bus,
    output logic                  busy,
    output logic                  acc_signal_load,
    output logic                  acc_signal_init,
    output logic                  acc_signal_neg,
    output logic                  acc_signal_oe,
    output logic [DATA_WIDTH-1:0] acc_data_in,
    output logic [ATTR_WIDTH-1:0] acc_attr_in,
    input  logic [DATA_WIDTH-1:0] acc_data_out,
    input  logic [ATTR_WIDTH-1:0] acc_attr_out
);
    state_t                state;
    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic [N_REQ-1:0]      grant_oh;
    logic                  first;
    logic                  res_valid_q;
    logic [DATA_WIDTH-1:0] res_data_q;
    logic [ATTR_WIDTH-1:0] res_attr_q;
    logic [ID_WIDTH-1:0]   res_id_q;

    logic [N_REQ-1:0]      arb_oh;
    logic [ID_WIDTH-1:0]   arb_idx;
    logic                  arb_any;

    logic                  sel_valid;
    logic                  sel_neg;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [ATTR_WIDTH-1:0] sel_attr;
    logic                  fire;
    logic [ID_WIDTH-1:0]   ptr_next;

    rr_arbiter #(.N(N_REQ), .IDX_W(ID_WIDTH)) u_arb (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .grant     (arb_oh),
        .grant_idx (arb_idx),
        .any_grant (arb_any)
    );

    assign sel_valid = bus.req_valid[grant_idx];
    assign sel_neg   = bus.req_neg[grant_idx];
    assign sel_last  = bus.req_last[grant_idx];
    assign sel_data  = bus.req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_attr  = bus.req_attr[int'(grant_idx)*ATTR_WIDTH +: ATTR_WIDTH];
    assign fire      = (state == ST_LOAD) && sel_valid;
    assign ptr_next  = (grant_idx == ID_WIDTH'(N_REQ - 1)) ? '0 : grant_idx + ID_WIDTH'(1);

    // Load strobes follow the granted stream directly so an operand costs no extra cycle.
    always_comb begin
        bus.req_ready   = '0;
        acc_signal_load = 1'b0;
        acc_signal_init = 1'b0;
        acc_signal_neg  = 1'b0;
        acc_data_in     = '0;
        acc_attr_in     = '0;
        if (state == ST_LOAD) begin
            bus.req_ready = grant_oh;
        end
        if (fire) begin
            acc_signal_load = 1'b1;
            acc_signal_init = first;
            acc_signal_neg  = sel_neg;
            acc_data_in     = sel_data;
            acc_attr_in     = sel_attr;
        end
    end

    assign acc_signal_oe = (state == ST_OE);
    assign busy          = (state != ST_IDLE);
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_attr  = res_attr_q;
    assign bus.res_id    = res_id_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            grant_idx   <= '0;
            grant_oh    <= '0;
            first       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_attr_q  <= '0;
            res_id_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        grant_idx <= arb_idx;
                        grant_oh  <= arb_oh;
                        first     <= 1'b1;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (sel_valid) begin
                        first <= 1'b0;
                        state <= sel_last ? ST_DRAIN : ST_GAP;
                    end
                end
                ST_GAP:   state <= ST_LOAD;
                ST_DRAIN: state <= ST_OE;
                ST_OE:    state <= ST_CAP;
                ST_CAP: begin
                    res_data_q  <= acc_data_out;
                    res_attr_q  <= acc_attr_out;
                    res_id_q    <= grant_idx;
                    res_valid_q <= 1'b1;
                    state       <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        rr_ptr      <= ptr_next;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
